// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the tinyalu: buffers commands in a FIFO,
// issues them one at a time on start/done and returns tagged responses.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/ready/a/b/op  command input (valid/ready), ready = !full
//   alu_A/B/op/start      tinyalu command, held stable while issued
//   alu_done/result       tinyalu completion
//   rsp_valid/ready       response handshake
//   rsp_result/op/status  result, opcode, 0 ok / 1 illegal / 2 timeout
// Optional: define ALU_SEQ_STATS_EN to add saturating 16-bit counters
//   stat_issued, stat_timeouts, stat_illegal.
module alu_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [7:0]  alu_A,
   output logic [7:0]  alu_B,
   output logic [2:0]  alu_op,
   output logic        alu_start,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic [1:0]  rsp_status
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0] stat_issued,
   output logic [15:0] stat_timeouts,
   output logic [15:0] stat_illegal
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   state_t state, state_n;

   logic [18:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic [7:0]    head_a, head_b;
   logic [2:0]    head_op;
   logic          is_nop, is_alu, is_ill;

   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    a_n, b_n;
   logic [2:0]    op_n, rop_n;
   logic          start_n, rvalid_n;
   logic [15:0]   result_n;
   logic [1:0]    status_n;

   // ---------------- command FIFO ----------------
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state == IDLE) && !empty;

   assign {head_a, head_b, head_op} = mem[rd_ptr];

   assign is_nop = (head_op == 3'd0);
   assign is_ill = (head_op > 3'd4);
   assign is_alu = !is_nop && !is_ill;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         alu_A      <= '0;
         alu_B      <= '0;
         alu_op     <= '0;
         alu_start  <= 1'b0;
         cnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_op     <= '0;
         rsp_status <= '0;
      end else begin
         state      <= state_n;
         alu_A      <= a_n;
         alu_B      <= b_n;
         alu_op     <= op_n;
         alu_start  <= start_n;
         cnt        <= cnt_n;
         rsp_valid  <= rvalid_n;
         rsp_result <= result_n;
         rsp_op     <= rop_n;
         rsp_status <= status_n;
      end
   end

   always_comb begin
      state_n  = state;
      a_n      = alu_A;
      b_n      = alu_B;
      op_n     = alu_op;
      start_n  = alu_start;
      cnt_n    = cnt;
      rvalid_n = rsp_valid;
      result_n = rsp_result;
      rop_n    = rsp_op;
      status_n = rsp_status;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               rop_n = head_op;
               unique case (1'b1)
                  is_alu: begin
                     a_n     = head_a;
                     b_n     = head_b;
                     op_n    = head_op;
                     start_n = 1'b1;
                     cnt_n   = '0;
                     state_n = ISSUE;
                  end
                  is_nop: begin
                     result_n = '0;
                     status_n = 2'd0;
                     rvalid_n = 1'b1;
                     state_n  = RESP;
                  end
                  is_ill: begin
                     result_n = '0;
                     status_n = 2'd1;
                     rvalid_n = 1'b1;
                     state_n  = RESP;
                  end
                  default: ;
               endcase
            end
         end
         ISSUE: begin
            // done has priority over an expiring timeout
            if (alu_done) begin
               result_n = alu_result;
               status_n = 2'd0;
               start_n  = 1'b0;
               rvalid_n = 1'b1;
               state_n  = RESP;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               result_n = '0;
               status_n = 2'd2;
               start_n  = 1'b0;
               rvalid_n = 1'b1;
               state_n  = RESP;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rvalid_n = 1'b0;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef ALU_SEQ_STATS_EN
   logic issue_ev, timeout_ev, illegal_ev;

   assign issue_ev   = (state == IDLE) && (state_n == ISSUE);
   assign timeout_ev = (state == ISSUE) && (state_n == RESP)
                       && (status_n == 2'd2);
   assign illegal_ev = (state == IDLE) && (state_n == RESP)
                       && (status_n == 2'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_issued   <= '0;
         stat_timeouts <= '0;
         stat_illegal  <= '0;
      end else begin
         if (issue_ev && stat_issued != 16'hFFFF)
            stat_issued <= stat_issued + 16'd1;
         if (timeout_ev && stat_timeouts != 16'hFFFF)
            stat_timeouts <= stat_timeouts + 16'd1;
         if (illegal_ev && stat_illegal != 16'hFFFF)
            stat_illegal <= stat_illegal + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: table of single commands against a
// behavioural tinyalu, plus hand sequences for latency/timeout/backpressure/reset.
module tb_alu_cmd_sequencer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_A, alu_B;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic [1:0]  rsp_status;
`ifdef ALU_SEQ_STATS_EN
   logic [15:0] stat_issued, stat_timeouts, stat_illegal;
`endif

   alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
      .alu_start(alu_start), .alu_done(alu_done),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_op(rsp_op),
      .rsp_status(rsp_status)
`ifdef ALU_SEQ_STATS_EN
      , .stat_issued(stat_issued), .stat_timeouts(stat_timeouts),
      .stat_illegal(stat_illegal)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------- behavioural tinyalu: add/and/xor 1 cycle, mul 3 ----------
   logic hang = 1'b0;
   int   lat_cnt = 0;

   function automatic int lat_of(input logic [2:0] op);
      return (op == 3'd4) ? 3 : 1;
   endfunction

   function automatic logic [15:0] calc(input logic [7:0] a, b,
                                        input logic [2:0] op);
      case (op)
         3'd1:    return {8'h00, a} + {8'h00, b};
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return {8'h00, a} * {8'h00, b};
         default: return 16'h0000;
      endcase
   endfunction

   initial begin
      alu_done   = 1'b0;
      alu_result = 16'h0;
   end

   always @(posedge clk) begin
      if (reset || !alu_start || alu_done) begin
         alu_done <= 1'b0;
         lat_cnt  <= 0;
      end else if (!hang) begin
         if (lat_cnt + 1 == lat_of(alu_op)) begin
            alu_done   <= 1'b1;
            alu_result <= calc(alu_A, alu_B, alu_op);
         end
         lat_cnt <= lat_cnt + 1;
      end
   end

   // ---------- monitors ----------
   typedef struct {
      logic [15:0] result;
      logic [2:0]  op;
      logic [1:0]  status;
   } rsp_t;

   rsp_t rsp_q[$];
   int   start_cycles = 0;
   int   accepts = 0;

   always @(posedge clk) begin
      if (!reset) begin
         if (rsp_valid && rsp_ready)
            rsp_q.push_back('{rsp_result, rsp_op, rsp_status});
         if (alu_start)
            start_cycles++;
         if (cmd_valid && cmd_ready)
            accepts++;
      end
   end

   // ---------- helpers ----------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op);
      int n;
      n = 0;
      cmd_a = a;
      cmd_b = b;
      cmd_op = op;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got cmd_ready=0 expected 1");
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output rsp_t r);
      int n;
      n = 0;
      while (rsp_q.size() == 0 && n < 200) begin
         tick();
         n++;
      end
      if (rsp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: got no response expected one");
         r = '{16'h0, 3'h0, 2'h0};
      end else begin
         r = rsp_q.pop_front();
      end
   endtask

   // ---------- vector table ----------
   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  op;
      logic [15:0] exp_result;
      logic [1:0]  exp_status;
      int          exp_start;
   } vec_t;

   vec_t vecs[10];
   vec_t bp[6];

   initial begin
      rsp_t r;
      int   base;

      vecs[0] = '{8'h12, 8'h34, 3'd1, 16'h0046, 2'd0, 2};
      vecs[1] = '{8'hFF, 8'hFF, 3'd4, 16'hFE01, 2'd0, 4};
      vecs[2] = '{8'hF0, 8'h3C, 3'd2, 16'h0030, 2'd0, 2};
      vecs[3] = '{8'hAA, 8'h0F, 3'd3, 16'h00A5, 2'd0, 2};
      vecs[4] = '{8'h55, 8'h66, 3'd0, 16'h0000, 2'd0, 0};
      vecs[5] = '{8'h11, 8'h22, 3'd6, 16'h0000, 2'd1, 0};
      vecs[6] = '{8'h33, 8'h44, 3'd7, 16'h0000, 2'd1, 0};
      vecs[7] = '{8'h01, 8'h02, 3'd5, 16'h0000, 2'd1, 0};
      vecs[8] = '{8'hFF, 8'h01, 3'd1, 16'h0100, 2'd0, 2};
      vecs[9] = '{8'h10, 8'h10, 3'd4, 16'h0100, 2'd0, 4};

      bp[0] = '{8'h01, 8'h03, 3'd3, 16'h0002, 2'd0, 0};
      bp[1] = '{8'h0F, 8'h3C, 3'd2, 16'h000C, 2'd0, 0};
      bp[2] = '{8'hFF, 8'h0F, 3'd3, 16'h00F0, 2'd0, 0};
      bp[3] = '{8'hAA, 8'h55, 3'd2, 16'h0000, 2'd0, 0};
      bp[4] = '{8'h5A, 8'hA5, 3'd3, 16'h00FF, 2'd0, 0};
      bp[5] = '{8'hC3, 8'hFF, 3'd2, 16'h00C3, 2'd0, 0};

      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_a = '0;
      cmd_b = '0;
      cmd_op = '0;
      rsp_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      // reset state
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_alu_start", 32'(alu_start), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_alu_regs", {13'd0, alu_op, alu_A, alu_B}, 32'd0);
      check("rst_rsp_regs", {11'd0, rsp_status, rsp_op, rsp_result}, 32'd0);

      // minimum latency: accept at N, start after N+1, rsp after N+3
      push(8'h12, 8'h34, 3'd1);
      check("lat_start_n0", 32'(alu_start), 32'd0);
      tick();
      check("lat_start_n1", 32'(alu_start), 32'd1);
      check("lat_alu_a", 32'(alu_A), 32'h12);
      tick();
      check("lat_valid_n2", 32'(rsp_valid), 32'd0);
      tick();
      check("lat_valid_n3", 32'(rsp_valid), 32'd1);
      check("lat_result", 32'(rsp_result), 32'h0046);
      get_rsp(r);
      check("lat_q_op", 32'(r.op), 32'd1);

      // table of single commands
      for (int i = 0; i < 10; i++) begin
         base = start_cycles;
         push(vecs[i].a, vecs[i].b, vecs[i].op);
         get_rsp(r);
         check($sformatf("v%0d_result", i), 32'(r.result),
               32'(vecs[i].exp_result));
         check($sformatf("v%0d_status", i), 32'(r.status),
               32'(vecs[i].exp_status));
         check($sformatf("v%0d_op", i), 32'(r.op), 32'(vecs[i].op));
         repeat (2) tick();
         check($sformatf("v%0d_start_cycles", i), start_cycles - base,
               vecs[i].exp_start);
      end

      // no_op then illegal back to back: two responses, in order
      base = start_cycles;
      push(8'h01, 8'h01, 3'd0);
      push(8'h02, 8'h02, 3'd6);
      get_rsp(r);
      check("seq_nop_op", {r.status, r.op, r.result}, {2'd0, 3'd0, 16'h0});
      get_rsp(r);
      check("seq_ill_op", {r.status, r.op, r.result}, {2'd1, 3'd6, 16'h0});
      check("seq_no_start", start_cycles - base, 0);

      // timeout on a hung add, queued xor then runs normally
      hang = 1'b1;
      base = start_cycles;
      push(8'h01, 8'h02, 3'd1);
      push(8'h0F, 8'hF0, 3'd3);
      get_rsp(r);
      hang = 1'b0;
      check("to_status", 32'(r.status), 32'd2);
      check("to_result", 32'(r.result), 32'd0);
      check("to_op", 32'(r.op), 32'd1);
      check("to_start_cycles", start_cycles - base, TIMEOUT);
      get_rsp(r);
      check("to_next", {r.status, r.op, r.result}, {2'd0, 3'd3, 16'h00FF});

      // backpressure: DEPTH+1 accepts, then full
      rsp_ready = 1'b0;
      base = accepts;
      for (int i = 0; i < DEPTH + 1; i++)
         push(bp[i].a, bp[i].b, bp[i].op);
      check("bp_full", 32'(cmd_ready), 32'd0);
      cmd_a = bp[5].a;
      cmd_b = bp[5].b;
      cmd_op = bp[5].op;
      cmd_valid = 1'b1;
      repeat (8) tick();
      check("bp_accepts", accepts - base, DEPTH + 1);
      check("bp_still_full", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      push(bp[5].a, bp[5].b, bp[5].op);
      for (int i = 0; i < 6; i++) begin
         get_rsp(r);
         check($sformatf("bp%0d_rsp", i), {r.status, r.op, r.result},
               {bp[i].exp_status, bp[i].op, bp[i].exp_result});
      end

      // reset during ISSUE with 3 queued commands
      hang = 1'b1;
      push(8'h01, 8'h01, 3'd1);
      push(8'h02, 8'h02, 3'd2);
      push(8'h03, 8'h03, 3'd3);
      push(8'h04, 8'h04, 3'd4);
      check("mr_issuing", 32'(alu_start), 32'd1);
      reset = 1'b1;
      tick();
      check("mr_start", 32'(alu_start), 32'd0);
      check("mr_valid", 32'(rsp_valid), 32'd0);
      check("mr_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      hang = 1'b0;
      base = start_cycles;
      repeat (40) tick();
      check("mr_no_rsp", rsp_q.size(), 0);
      check("mr_no_issue", start_cycles - base, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
